// File: rtl/ff_bank_if.sv
// Control/data bundle for ff_bank: update controls and operands in, stored
// state and invalid-input tracking out.
interface ff_bank_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    // No valid/ready pair: the bank samples every input on every rising edge,
    // and its outputs are always valid (the previous edge's result).
    logic             en;
    logic             clr;
    logic [1:0]       mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             err_clr;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_bar;
    logic [WIDTH-1:0] err_mask;
    logic [CNT_W-1:0] err_cnt;

    modport master (
        output en, clr, mode, a, b, err_clr,
        input  q, q_bar, err_mask, err_cnt
    );

    modport slave (
        input  en, clr, mode, a, b, err_clr,
        output q, q_bar, err_mask, err_cnt
    );
endinterface

// File: rtl/ff_bank.sv
// Bank of WIDTH run-time selectable SR/JK/D/T storage bits with synchronous
// enable and clear, plus sticky per-bit and counted SR invalid-input tracking.
module ff_bank #(
    parameter int                 WIDTH   = 8,
    parameter logic [WIDTH-1:0]   RST_VAL = {WIDTH{1'b0}},
    parameter int                 SR_BOTH = 0,
    parameter int                 CNT_W   = 4
) (
    input  logic     clk,
    input  logic     n_rst,
    ff_bank_if.slave bus
);
    localparam logic [1:0] MODE_SR = 2'b00;
    localparam logic [1:0] MODE_JK = 2'b01;
    localparam logic [1:0] MODE_D  = 2'b10;
    localparam logic [1:0] MODE_T  = 2'b11;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] mask_r;
    logic [CNT_W-1:0] cnt_r;

    logic [WIDTH-1:0] hold_bits;
    logic [WIDTH-1:0] set_bits;
    logic [WIDTH-1:0] both_bits;
    logic [WIDTH-1:0] sr_both_val;
    logic [WIDTH-1:0] sr_next;
    logic [WIDTH-1:0] jk_next;
    logic [WIDTH-1:0] mode_next;
    logic [WIDTH-1:0] q_next;
    logic             inv_evt;

    assign hold_bits = ~bus.a & ~bus.b;
    assign set_bits  =  bus.a & ~bus.b;
    assign both_bits =  bus.a &  bus.b;

    // Value a bit takes in SR mode when S=R=1; only this case is configurable.
    always_comb begin
        sr_both_val = q_r;
        case (SR_BOTH)
            1:       sr_both_val = {WIDTH{1'b1}};
            2:       sr_both_val = {WIDTH{1'b0}};
            3:       sr_both_val = ~q_r;
            default: sr_both_val = q_r;
        endcase
    end

    // Reset bits (a=0,b=1) fall out as zero because no term selects them.
    assign sr_next = (q_r & hold_bits) | set_bits | (both_bits & sr_both_val);
    assign jk_next = (q_r & hold_bits) | set_bits | (both_bits & ~q_r);

    always_comb begin
        mode_next = q_r;
        case (bus.mode)
            MODE_SR: mode_next = sr_next;
            MODE_JK: mode_next = jk_next;
            MODE_D:  mode_next = bus.a;
            MODE_T:  mode_next = q_r ^ bus.a;
            default: mode_next = q_r;
        endcase
    end

    always_comb begin
        q_next = q_r;
        if (bus.clr) begin
            q_next = RST_VAL;
        end else if (bus.en) begin
            q_next = mode_next;
        end
    end

    // Reset is handled by the register's async branch, so n_rst is implied high here.
    assign inv_evt = bus.en && !bus.clr && (bus.mode == MODE_SR) && (|both_bits);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            q_r <= RST_VAL;
        end else begin
            q_r <= q_next;
        end
    end

    // An event in the same cycle as err_clr restarts tracking from that event.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            mask_r <= {WIDTH{1'b0}};
            cnt_r  <= {CNT_W{1'b0}};
        end else if (inv_evt) begin
            if (bus.err_clr) begin
                mask_r <= both_bits;
                cnt_r  <= CNT_ONE;
            end else begin
                mask_r <= mask_r | both_bits;
                if (cnt_r != CNT_MAX) begin
                    cnt_r <= cnt_r + CNT_ONE;
                end
            end
        end else if (bus.err_clr) begin
            mask_r <= {WIDTH{1'b0}};
            cnt_r  <= {CNT_W{1'b0}};
        end
    end

    assign bus.q        = q_r;
    assign bus.q_bar    = ~q_r;
    assign bus.err_mask = mask_r;
    assign bus.err_cnt  = cnt_r;
endmodule

// File: doc/ff_bank.md
# ff_bank

Parametrised bank of WIDTH single-bit storage elements sharing one clock and one asynchronous active-low reset. It is the successor to the single SR flip-flop: the bank is run-time selectable between SR, JK, D and T behaviour, the S=R=1 policy is configurable, and it has a synchronous enable, a synchronous clear, and invalid-input tracking. It serves as the generic flag/state register primitive for control blocks in the same design.

## Interface

Parameters:
- WIDTH, 8: number of storage bits.
- RST_VAL, {WIDTH{1'b0}}: value loaded into q by n_rst and by clr.
- SR_BOTH, 0: SR-mode response to a=b=1 on a bit. 0 = hold, 1 = set, 2 = reset, 3 = toggle.
- CNT_W, 4: width of the invalid-event counter.

Ports:
- clk, input, 1: sole clock; all state updates on the rising edge.
- n_rst, input, 1: asynchronous, active-low reset.
- en, input, 1: update enable. When low, q holds.
- clr, input, 1: synchronous clear of q to RST_VAL. Has priority over en.
- mode, input, 2: 00 SR, 01 JK, 10 D, 11 T. Sampled every edge.
- a, input, WIDTH: S / J / D / T per bit, depending on mode.
- b, input, WIDTH: R / K per bit. Ignored in D and T modes.
- err_clr, input, 1: synchronous clear of err_cnt and err_mask.
- q, output, WIDTH: registered state.
- q_bar, output, WIDTH: combinational ~q, always the exact complement, including during reset.
- err_mask, output, WIDTH: sticky per-bit record of SR a=b=1 events.
- err_cnt, output, CNT_W: saturating count of cycles containing at least one SR invalid event.

## Operation

- Reset (n_rst=0, asynchronous): q=RST_VAL, q_bar=~RST_VAL, err_mask=0, err_cnt=0. These values hold while n_rst is low, regardless of clk.
- Update priority at each edge: clr, then en. If clr=1, q=RST_VAL. Else if en=0, q holds. Else each bit i is updated per mode:
  - SR: a=1,b=0 sets the bit. a=0,b=1 resets it. a=0,b=0 holds. a=1,b=1 follows SR_BOTH.
  - JK: same as SR, except a=b=1 always toggles.
  - D: q[i]=a[i].
  - T: q[i] toggles when a[i]=1 and holds otherwise.
- Bits are independent. There is no cross-bit interaction.
- Invalid event: a cycle with n_rst=1, clr=0, en=1, mode=SR, and (a&b)≠0.
  - On such a cycle, err_mask |= (a&b).
  - On such a cycle, err_cnt increments by 1, saturating at 2^CNT_W−1. It never wraps.
  - Invalid tracking is independent of SR_BOTH. The configured action is still applied to q.
- err_clr=1 with no invalid event in the same cycle: err_mask=0 and err_cnt=0 at the next edge.
- err_clr=1 with an invalid event in the same cycle: the event wins. err_mask=(a&b) and err_cnt=1.
- clr does not affect err_mask or err_cnt.
- A mode change takes effect on the same edge it is sampled at. There is no pipeline and no history is carried across modes.

## Timing

- Latency of a, b, mode, en and clr to q: one clock edge.
- q_bar follows q combinationally, with no additional cycle.
- err_mask and err_cnt update on the same edge as the q update that caused the event.
- Reset asserted mid-operation immediately forces the reset values; in-flight inputs are discarded.
- Reset deassertion: the first update occurs on the first rising edge with n_rst=1.
- Each output is a direct register output, or its inversion in the case of q_bar. There are no combinational paths from inputs to q or to the err outputs.

## Test plan

- Reset with WIDTH=8, RST_VAL=8'hA5:
  - Drive n_rst=0 asynchronously mid-cycle -> q=A5, q_bar=5A, err_mask=00, err_cnt=0 immediately, with no edge required.
  - Release n_rst, then apply D mode with a=3C -> q=3C one edge later.
- SR mode from q=00 with en=1:
  - a=0F, b=00 -> q=0F.
  - Then a=00, b=03 -> q=0C.
  - Then a=04, b=04 with SR_BOTH=0 -> q=0C, err_mask=04, err_cnt=1.
  - Repeat the a=b=1 case with SR_BOTH=3 -> bit 2 toggles, giving q=08.
- JK and T modes:
  - JK, q=F0, a=FF, b=FF -> q=0F, err_cnt unchanged.
  - T, a=81 for two edges -> q=8E, then q=0F.
- Enable and clear priority:
  - en=0, D mode, a=FF -> q holds.
  - clr=1 with en=1 and a=FF -> q=RST_VAL.
  - clr=1 with en=0 -> q=RST_VAL.
- Counter saturation and err_clr, with CNT_W=4:
  - 20 consecutive SR invalid cycles -> err_cnt stops at 15.
  - err_clr alone -> err_cnt=0 and err_mask=00 next edge.
  - err_clr together with an event on a=b=10 -> err_cnt=1, err_mask=10.
- Mode switching every cycle (SR→D→T→JK) with random a and b over 1000 cycles -> q matches the reference model every edge, and q_bar=~q at all times.
